// File: rtl/ndn_fib_pkg.sv
// Shared widths and record types for the NDN FIB lookup pipeline.
package ndn_fib_pkg;

  localparam int unsigned WORD_SIZE         = 32;
  localparam int unsigned TREE_HEIGHT       = 4;
  localparam int unsigned POINTER_SIZE      = 6;
  localparam int unsigned MAX_NAME_LENGTH   = 8;
  localparam int unsigned STRIDE_INDEX_SIZE = 3;

  typedef logic [MAX_NAME_LENGTH-1:0][WORD_SIZE-1:0] words_t;

  // 48-bit node layout: {valid, key, stride, left, right}
  typedef struct packed {
    logic                         valid;
    logic [WORD_SIZE-1:0]         key;
    logic [STRIDE_INDEX_SIZE-1:0] stride;
    logic [POINTER_SIZE-1:0]      left;
    logic [POINTER_SIZE-1:0]      right;
  } node_t;

  typedef struct packed {
    words_t                  words;
    logic [POINTER_SIZE-1:0] addr;
    logic                    valid;
  } stage_reg_t;

endpackage

// File: rtl/ndn_fib_stage.sv
// One search-tree level: private node table, key compare and next-pointer select.
// Stride output register exists only with NDN_FIB_DEBUG_PORTS_EN defined.
module ndn_fib_stage
  import ndn_fib_pkg::*;
#(
  parameter int unsigned STAGE_ID = 0
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         tbl_wr_en,
  input  logic [1:0]                   tbl_wr_stage,
  input  logic [POINTER_SIZE-1:0]      tbl_wr_addr,
  input  node_t                        tbl_wr_data,
  input  stage_reg_t                   cur,
  output stage_reg_t                   nxt,
  output logic                         match_flag,
  output logic [STRIDE_INDEX_SIZE-1:0] stride
);

  node_t                tbl [2**POINTER_SIZE];
  node_t                node;
  logic [WORD_SIZE-1:0] w;
  logic                 hit;
  logic                 match_q;

  // Not reset: tables are programmed by software before any lookup.
  always_ff @(posedge clk_in) begin
    if (tbl_wr_en && (tbl_wr_stage == 2'(STAGE_ID))) begin
      tbl[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  always_comb begin
    node      = tbl[cur.addr];
    w         = cur.words[node.stride];
    hit       = cur.valid & node.valid & (w == node.key);
    nxt.words = cur.words;
    nxt.addr  = (w < node.key) ? node.left : node.right;
    nxt.valid = cur.valid & node.valid;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
    end
  end

  assign match_flag = match_q;

`ifdef NDN_FIB_DEBUG_PORTS_EN
  logic [STRIDE_INDEX_SIZE-1:0] stride_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stride_q <= '0;
    end else begin
      stride_q <= cur.valid ? node.stride : '0;
    end
  end

  assign stride = stride_q;
`else
  assign stride = '0;
`endif

endmodule

// File: rtl/ndn_fib_lookup_pipe.sv
// NDN FIB lookup: assembles 8-word names and walks them through TREE_HEIGHT table stages.
// Debug outputs are driven only when NDN_FIB_DEBUG_PORTS_EN is defined, otherwise tied to 0.
module ndn_fib_lookup_pipe
  import ndn_fib_pkg::*;
(
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [WORD_SIZE-1:0]         name_component,
  input  logic                         name_valid,
  input  logic                         tbl_wr_en,
  input  logic [1:0]                   tbl_wr_stage,
  input  logic [POINTER_SIZE-1:0]      tbl_wr_addr,
  input  logic [47:0]                  tbl_wr_data,
  output logic                         dummy_output_0,
  output logic                         dummy_output_1,
  output logic                         dummy_output_2,
  output logic                         dummy_output_3,
  output logic [STRIDE_INDEX_SIZE-1:0] stageStrideIndex_0,
  output logic [STRIDE_INDEX_SIZE-1:0] stageStrideIndex_1,
  output logic [STRIDE_INDEX_SIZE-1:0] stageStrideIndex_2,
  output logic [STRIDE_INDEX_SIZE-1:0] stageStrideIndex_3,
  output logic [WORD_SIZE-1:0]         words_pipeline_3_0,
  output logic [WORD_SIZE-1:0]         words_pipeline_3_1,
  output logic [WORD_SIZE-1:0]         words_pipeline_3_2,
  output logic [WORD_SIZE-1:0]         words_pipeline_3_3,
  output logic [WORD_SIZE-1:0]         words_pipeline_3_4,
  output logic [WORD_SIZE-1:0]         words_pipeline_3_5,
  output logic [WORD_SIZE-1:0]         words_pipeline_3_6,
  output logic [WORD_SIZE-1:0]         words_pipeline_3_7,
  output logic                         debug_address_pipeline_reg_0
);

  logic [STRIDE_INDEX_SIZE-1:0]                  cnt_q;
  words_t                                        words_q;
  words_t                                        full_words;
  logic                                          name_done;
  node_t                                         wr_node;
  stage_reg_t                                    pipe_q [TREE_HEIGHT];
  stage_reg_t                                    nxt    [TREE_HEIGHT];
  logic [TREE_HEIGHT-1:0]                        match;
  logic [TREE_HEIGHT-1:0][STRIDE_INDEX_SIZE-1:0] stride;

  assign name_done = name_valid && (cnt_q == STRIDE_INDEX_SIZE'(MAX_NAME_LENGTH - 1));
  assign wr_node   = node_t'(tbl_wr_data);

  // Last word bypasses the buffer so stage 0 loads on the completing edge.
  always_comb begin
    full_words                    = words_q;
    full_words[MAX_NAME_LENGTH-1] = name_component;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q   <= '0;
      words_q <= '0;
      for (int k = 0; k < TREE_HEIGHT; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      if (name_valid) begin
        words_q[cnt_q] <= name_component;
        cnt_q          <= name_done ? '0 : cnt_q + 1'b1;
      end
      pipe_q[0].valid <= name_done;
      if (name_done) begin
        pipe_q[0].words <= full_words;
        pipe_q[0].addr  <= '0;
      end
      for (int k = 1; k < TREE_HEIGHT; k++) begin
        pipe_q[k] <= nxt[k-1];
      end
    end
  end

  for (genvar k = 0; k < TREE_HEIGHT; k++) begin : g_stage
    ndn_fib_stage #(
      .STAGE_ID(k)
    ) u_stage (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .tbl_wr_en   (tbl_wr_en),
      .tbl_wr_stage(tbl_wr_stage),
      .tbl_wr_addr (tbl_wr_addr),
      .tbl_wr_data (wr_node),
      .cur         (pipe_q[k]),
      .nxt         (nxt[k]),
      .match_flag  (match[k]),
      .stride      (stride[k])
    );
  end

  assign dummy_output_0     = match[0];
  assign dummy_output_1     = match[1];
  assign dummy_output_2     = match[2];
  assign dummy_output_3     = match[3];
  assign stageStrideIndex_0 = stride[0];
  assign stageStrideIndex_1 = stride[1];
  assign stageStrideIndex_2 = stride[2];
  assign stageStrideIndex_3 = stride[3];

`ifdef NDN_FIB_DEBUG_PORTS_EN
  assign words_pipeline_3_0           = pipe_q[3].words[0];
  assign words_pipeline_3_1           = pipe_q[3].words[1];
  assign words_pipeline_3_2           = pipe_q[3].words[2];
  assign words_pipeline_3_3           = pipe_q[3].words[3];
  assign words_pipeline_3_4           = pipe_q[3].words[4];
  assign words_pipeline_3_5           = pipe_q[3].words[5];
  assign words_pipeline_3_6           = pipe_q[3].words[6];
  assign words_pipeline_3_7           = pipe_q[3].words[7];
  assign debug_address_pipeline_reg_0 = pipe_q[0].addr[0];
`else
  assign words_pipeline_3_0           = '0;
  assign words_pipeline_3_1           = '0;
  assign words_pipeline_3_2           = '0;
  assign words_pipeline_3_3           = '0;
  assign words_pipeline_3_4           = '0;
  assign words_pipeline_3_5           = '0;
  assign words_pipeline_3_6           = '0;
  assign words_pipeline_3_7           = '0;
  assign debug_address_pipeline_reg_0 = 1'b0;
`endif

endmodule

// File: tb/tb_ndn_fib_lookup_pipe.sv
// Scoreboard bench for ndn_fib_lookup_pipe; debug-port expectations follow NDN_FIB_DEBUG_PORTS_EN.
module tb_ndn_fib_lookup_pipe;

`ifdef NDN_FIB_DEBUG_PORTS_EN
  localparam bit DbgEn = 1'b1;
`else
  localparam bit DbgEn = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [31:0] name_component;
  logic        name_valid;
  logic        tbl_wr_en;
  logic [1:0]  tbl_wr_stage;
  logic [5:0]  tbl_wr_addr;
  logic [47:0] tbl_wr_data;
  logic        do0, do1, do2, do3;
  logic [2:0]  si0, si1, si2, si3;
  logic [31:0] wp0, wp1, wp2, wp3, wp4, wp5, wp6, wp7;
  logic        dbg_addr;

  ndn_fib_lookup_pipe dut (
    .clk_in                      (clk_in),
    .rst_n_in                    (rst_n_in),
    .name_component              (name_component),
    .name_valid                  (name_valid),
    .tbl_wr_en                   (tbl_wr_en),
    .tbl_wr_stage                (tbl_wr_stage),
    .tbl_wr_addr                 (tbl_wr_addr),
    .tbl_wr_data                 (tbl_wr_data),
    .dummy_output_0              (do0),
    .dummy_output_1              (do1),
    .dummy_output_2              (do2),
    .dummy_output_3              (do3),
    .stageStrideIndex_0          (si0),
    .stageStrideIndex_1          (si1),
    .stageStrideIndex_2          (si2),
    .stageStrideIndex_3          (si3),
    .words_pipeline_3_0          (wp0),
    .words_pipeline_3_1          (wp1),
    .words_pipeline_3_2          (wp2),
    .words_pipeline_3_3          (wp3),
    .words_pipeline_3_4          (wp4),
    .words_pipeline_3_5          (wp5),
    .words_pipeline_3_6          (wp6),
    .words_pipeline_3_7          (wp7),
    .debug_address_pipeline_reg_0(dbg_addr)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int unsigned           e;
    logic [3:0]            m;
    logic [3:0][2:0]       s;
    logic [7:0][31:0]      w;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  bit          mon_en   = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: each name owns stage k's outputs at edge E+1+k; all else must be idle (zero).
  always @(negedge clk_in) begin : mon
    logic [3:0]       em, am;
    logic [3:0][2:0]  es, as_;
    logic [7:0][31:0] aw, ew;
    int               k;
    if (mon_en) begin
      em  = '0;
      es  = '0;
      am  = {do3, do2, do1, do0};
      as_ = {si3, si2, si1, si0};
      if (q.size() != 0 && cyc > q[0].e && cyc <= q[0].e + 4) begin
        k     = int'(cyc - q[0].e) - 1;
        em[k] = q[0].m[k];
        es[k] = q[0].s[k];
        if (cyc == q[0].e + 3) begin
          aw = {wp7, wp6, wp5, wp4, wp3, wp2, wp1, wp0};
          ew = DbgEn ? q[0].w : '0;
          chk("words_pipeline_3", 256'(aw), 256'(ew));
        end
      end
      if (!DbgEn) es = '0;
      chk("match_flags", 256'(am), 256'(em));
      chk("stride_idx", 256'(as_), 256'(es));
      chk("debug_addr0", 256'(dbg_addr), 256'(0));
      if (q.size() != 0 && cyc >= q[0].e + 4) void'(q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input int st, input int addr, input logic v, input logic [31:0] key,
                    input logic [2:0] str, input logic [5:0] l, input logic [5:0] r);
    tbl_wr_en    = 1'b1;
    tbl_wr_stage = st[1:0];
    tbl_wr_addr  = addr[5:0];
    tbl_wr_data  = {v, key, str, l, r};
    tick();
    tbl_wr_en    = 1'b0;
  endtask

  task automatic send_name(input logic [7:0][31:0] w, input bit gap, input logic [3:0] m,
                           input logic [3:0][2:0] s);
    exp_t x;
    for (int i = 0; i < 8; i++) begin
      name_valid     = 1'b1;
      name_component = w[i];
      tick();
      name_valid = 1'b0;
      if (i == 7) begin
        x.e = cyc;
        x.m = m;
        x.s = s;
        x.w = w;
        q.push_back(x);
      end
      if (gap) tick();
    end
  endtask

  logic [7:0][31:0] root_w, na, nb;
  logic [3:0][2:0]  s_root, s_walk, s_inv;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) root_w[i] = 32'(i);
    root_w[0] = 32'hAA;
    na = {32'h77, 32'h06, 32'h05, 32'h04, 32'h33, 32'h10, 32'h11, 32'h01};
    nb = na;
    nb[2] = 32'h60;
    s_root = '0;
    s_walk = '0;
    s_walk[0] = 3'd2; s_walk[1] = 3'd1; s_walk[2] = 3'd3; s_walk[3] = 3'd7;
    s_inv = '0;
    s_inv[0] = 3'd2;

    rst_n_in = 1'b0;
    name_valid = 1'b0;
    name_component = '0;
    tbl_wr_en = 1'b0;
    tbl_wr_stage = '0;
    tbl_wr_addr = '0;
    tbl_wr_data = '0;
    repeat (3) tick();
    rst_n_in = 1'b1;
    mon_en   = 1'b1;

    for (int st = 0; st < 4; st++)
      for (int a = 0; a < 64; a++) wr(st, a, 1'b0, 32'h0, 3'd0, 6'd0, 6'd0);

    // Root hit, then reset with three words of the next name accepted.
    wr(0, 0, 1'b1, 32'hAA, 3'd0, 6'd1, 6'd2);
    send_name(root_w, 1'b0, 4'b0001, s_root);
    for (int i = 0; i < 3; i++) begin
      name_valid = 1'b1;
      name_component = 32'hDEAD0000 + 32'(i);
      tick();
    end
    name_valid = 1'b0;
    mon_en = 1'b0;
    q.delete();
    rst_n_in = 1'b0;
    #1;
    chk("reset_match", 256'({do3, do2, do1, do0}), 256'(0));
    chk("reset_stride", 256'({si3, si2, si1, si0}), 256'(0));
    chk("reset_words", 256'({wp7, wp6, wp5, wp4, wp3, wp2, wp1, wp0}), 256'(0));
    chk("reset_dbg", 256'(dbg_addr), 256'(0));
    tick();
    rst_n_in = 1'b1;
    mon_en = 1'b1;
    send_name(root_w, 1'b0, 4'b0001, s_root);
    repeat (6) tick();

    // Left/right walk through all four levels.
    wr(0, 0, 1'b1, 32'h50, 3'd2, 6'd3, 6'd5);
    wr(1, 3, 1'b1, 32'h11, 3'd1, 6'd0, 6'd0);
    wr(1, 5, 1'b1, 32'h99, 3'd1, 6'd0, 6'd0);
    wr(2, 0, 1'b1, 32'h33, 3'd3, 6'd7, 6'd9);
    wr(3, 9, 1'b1, 32'h77, 3'd7, 6'd0, 6'd0);
    send_name(na, 1'b0, 4'b1110, s_walk);
    repeat (6) tick();
    send_name(nb, 1'b0, 4'b1100, s_walk);
    repeat (6) tick();

    // Invalid root node blocks propagation.
    wr(0, 0, 1'b0, 32'h50, 3'd2, 6'd3, 6'd5);
    send_name(na, 1'b0, 4'b0000, s_inv);
    repeat (6) tick();

    // Back-to-back names, then the same pair with one idle cycle after every word.
    wr(0, 0, 1'b1, 32'h50, 3'd2, 6'd3, 6'd5);
    send_name(na, 1'b0, 4'b1110, s_walk);
    send_name(nb, 1'b0, 4'b1100, s_walk);
    send_name(na, 1'b1, 4'b1110, s_walk);
    send_name(nb, 1'b1, 4'b1100, s_walk);

    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
